// File: rtl/pc_core_adder_arbiter_if.sv
// AXI-Stream style bundle shared by the two requester ports and the master port
// of the adder arbiter. tkeep is a fixed 8-bit field.
interface pc_core_adder_arbiter_if #(
    parameter int DATA_WIDTH = 512
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [7:0]            tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/pc_core_adder_arbiter.sv
// Two-requester round-robin packet arbiter feeding the adder core, latching the winner's constant.
// Optional beat counters are built only when PC_CORE_ARB_STATS_EN is defined.
module pc_core_adder_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_AXIS_TID_WIDTH   = 1
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          ctrl_enable,
    input  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant0,
    input  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant1,
    pc_core_adder_arbiter_if.slave        s0_axis,
    pc_core_adder_arbiter_if.slave        s1_axis,
    pc_core_adder_arbiter_if.master       m_axis,
    output logic [C_AXIS_TID_WIDTH-1:0]   m_axis_tid,
    output logic [C_ADDER_BIT_WIDTH-1:0]  m_ctrl_constant,
    output logic [31:0]                   stat_beats0,
    output logic [31:0]                   stat_beats1
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                         state_r;
    logic                           rr_r;
    logic                           gnt_r;
    logic [C_ADDER_BIT_WIDTH-1:0]   const_r;
    logic                           grant_s;
    logic                           xfer_s;

    // Requester rr wins when valid, otherwise the other one takes the slot.
    function automatic logic pick_grant(input logic rr, input logic v0, input logic v1);
        logic g;
        if (rr) begin
            g = v1;
        end else begin
            g = ~v0;
        end
        return g;
    endfunction

    assign grant_s = pick_grant(rr_r, s0_axis.tvalid, s1_axis.tvalid);
    assign xfer_s  = m_axis.tvalid && m_axis.tready;

    // Arbitration FSM: grant, constant capture and pointer update at packet end.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_r <= ST_IDLE;
            rr_r    <= 1'b0;
            gnt_r   <= 1'b0;
            const_r <= {C_ADDER_BIT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_enable && (s0_axis.tvalid || s1_axis.tvalid)) begin
                        gnt_r   <= grant_s;
                        const_r <= grant_s ? ctrl_constant1 : ctrl_constant0;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (xfer_s && m_axis.tlast) begin
                        rr_r    <= ~gnt_r;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ctrl_constant = const_r;

    // Steer the granted requester onto the master stream; tready only flows back to it.
    always_comb begin
        m_axis.tvalid  = 1'b0;
        m_axis.tdata   = {C_AXIS_TDATA_WIDTH{1'b0}};
        m_axis.tkeep   = 8'h00;
        m_axis.tlast   = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        m_axis_tid     = {C_AXIS_TID_WIDTH{1'b0}};
        if (state_r == ST_BUSY) begin
            m_axis_tid[0] = gnt_r;
            if (gnt_r) begin
                m_axis.tvalid  = s1_axis.tvalid;
                m_axis.tdata   = s1_axis.tdata;
                m_axis.tkeep   = s1_axis.tkeep;
                m_axis.tlast   = s1_axis.tlast;
                s1_axis.tready = m_axis.tready;
            end else begin
                m_axis.tvalid  = s0_axis.tvalid;
                m_axis.tdata   = s0_axis.tdata;
                m_axis.tkeep   = s0_axis.tkeep;
                m_axis.tlast   = s0_axis.tlast;
                s0_axis.tready = m_axis.tready;
            end
        end else begin
            m_axis_tid = {C_AXIS_TID_WIDTH{1'b0}};
        end
    end

`ifdef PC_CORE_ARB_STATS_EN
    logic [31:0] stat0_r;
    logic [31:0] stat1_r;
    logic        xfer0_s;
    logic        xfer1_s;

    assign xfer0_s = s0_axis.tvalid && s0_axis.tready;
    assign xfer1_s = s1_axis.tvalid && s1_axis.tready;

    // Saturating accepted-beat counters, one per requester.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            stat0_r <= 32'd0;
            stat1_r <= 32'd0;
        end else begin
            if (xfer0_s && (stat0_r != 32'hFFFF_FFFF)) begin
                stat0_r <= stat0_r + 32'd1;
            end
            if (xfer1_s && (stat1_r != 32'hFFFF_FFFF)) begin
                stat1_r <= stat1_r + 32'd1;
            end
        end
    end

    assign stat_beats0 = stat0_r;
    assign stat_beats1 = stat1_r;
`else
    assign stat_beats0 = 32'd0;
    assign stat_beats1 = 32'd0;
`endif

endmodule

// File: tb/tb_pc_core_adder_arbiter.sv
// Directed self-checking bench for pc_core_adder_arbiter; expected stat values
// follow whether PC_CORE_ARB_STATS_EN is defined for the build.
`timescale 1ns/1ps
module tb_pc_core_adder_arbiter;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TW = 1;

    logic          s_axis_aclk = 1'b0;
    logic          s_axis_areset;
    logic          ctrl_enable;
    logic [AW-1:0] ctrl_constant0;
    logic [AW-1:0] ctrl_constant1;
    logic [TW-1:0] m_axis_tid;
    logic [AW-1:0] m_ctrl_constant;
    logic [31:0]   stat_beats0;
    logic [31:0]   stat_beats1;
    int            n_cmp = 0;
    int            n_bad = 0;

    pc_core_adder_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    pc_core_adder_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    pc_core_adder_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    pc_core_adder_arbiter #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_ADDER_BIT_WIDTH (AW),
        .C_AXIS_TID_WIDTH  (TW)
    ) dut (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_areset  (s_axis_areset),
        .ctrl_enable    (ctrl_enable),
        .ctrl_constant0 (ctrl_constant0),
        .ctrl_constant1 (ctrl_constant1),
        .s0_axis        (s0_if.slave),
        .s1_axis        (s1_if.slave),
        .m_axis         (m_if.master),
        .m_axis_tid     (m_axis_tid),
        .m_ctrl_constant(m_ctrl_constant),
        .stat_beats0    (stat_beats0),
        .stat_beats1    (stat_beats1)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    function automatic logic [DW-1:0] beat_data(input int src, input int idx);
        return {32'(src + 1), 32'(idx + 1)};
    endfunction

    function automatic logic [7:0] keep_of(input int idx);
        return 8'(idx) ^ 8'hF0;
    endfunction

    task automatic tick();
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic set_src(input int src, input logic v, input int idx, input logic last);
        if (src == 0) begin
            s0_if.tvalid = v;
            s0_if.tdata  = beat_data(0, idx);
            s0_if.tkeep  = keep_of(idx);
            s0_if.tlast  = last;
        end else begin
            s1_if.tvalid = v;
            s1_if.tdata  = beat_data(1, idx);
            s1_if.tkeep  = keep_of(idx);
            s1_if.tlast  = last;
        end
    endtask

    task automatic do_reset();
        s_axis_areset  = 1'b1;
        ctrl_enable    = 1'b0;
        ctrl_constant0 = 32'd0;
        ctrl_constant1 = 32'd0;
        m_if.tready    = 1'b1;
        set_src(0, 1'b0, 0, 1'b0);
        set_src(1, 1'b0, 0, 1'b0);
        tick();
        tick();
        s_axis_areset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        s_axis_areset  = 1'b1;
        ctrl_enable    = 1'b1;
        ctrl_constant0 = 32'd11;
        ctrl_constant1 = 32'd12;
        m_if.tready    = 1'b1;
        set_src(0, 1'b1, 0, 1'b0);
        set_src(1, 1'b1, 0, 1'b0);
        #2;
        obs = {m_if.tvalid, s0_if.tready, s1_if.tready, m_axis_tid, 2'b00};
        n_cmp++;
        if (obs !== 6'b000000) begin n_bad++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b000000); end
        n_cmp++;
        if (m_ctrl_constant !== 32'd0) begin n_bad++; $display("FAIL reset_const: got %0d expected 0", m_ctrl_constant); end
        n_cmp++;
        if ({stat_beats0, stat_beats1} !== 64'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_beats0, stat_beats1); end
        tick();
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_held_tvalid: got %b expected 0", m_if.tvalid); end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        ctrl_enable    = 1'b1;
        ctrl_constant0 = 32'd5;
        ctrl_constant1 = 32'd99;
        set_src(0, 1'b1, 0, 1'b0);
        #1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL single_arb_cycle_tvalid: got %b expected 0", m_if.tvalid); end
        tick();
        for (int b = 0; b < 4; b++) begin
            set_src(0, 1'b1, b, (b == 3));
            #1;
            obs = {m_if.tvalid, m_if.tlast, s0_if.tready, s1_if.tready};
            exp = {1'b1, (b == 3), 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL single_ctrl beat %0d: got %b expected %b", b, obs, exp); end
            n_cmp++;
            if (m_if.tdata !== beat_data(0, b) || m_if.tkeep !== keep_of(b)) begin
                n_bad++; $display("FAIL single_data beat %0d: got %h/%h expected %h/%h", b, m_if.tdata, m_if.tkeep, beat_data(0, b), keep_of(b));
            end
            n_cmp++;
            if (m_axis_tid !== 1'b0 || m_ctrl_constant !== 32'd5) begin
                n_bad++; $display("FAIL single_tid_const beat %0d: got %0d/%0d expected 0/5", b, m_axis_tid, m_ctrl_constant);
            end
            tick();
        end
        set_src(0, 1'b0, 0, 1'b0);
        #1;
        n_cmp++;
        if ({m_if.tvalid, s0_if.tready} !== 2'b00) begin n_bad++; $display("FAIL single_end_idle: got %b expected 00", {m_if.tvalid, s0_if.tready}); end
    endtask

    task automatic test_contention();
        int c0 = 0;
        int c1 = 0;
        logic exp_v;
        logic exp_tid;
        logic exp_last;
        do_reset();
        ctrl_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_src(0, 1'b1, c0, (c0 % 2 == 1));
            set_src(1, 1'b1, c1, (c1 % 2 == 1));
            #1;
            exp_v    = (i % 3 != 0);
            exp_tid  = ((i / 3) % 2 == 1);
            exp_last = (i % 3 == 2);
            n_cmp++;
            if (m_if.tvalid !== exp_v) begin n_bad++; $display("FAIL contention_tvalid cyc %0d: got %b expected %b", i, m_if.tvalid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if ({m_axis_tid, m_if.tlast} !== {exp_tid, exp_last}) begin
                    n_bad++; $display("FAIL contention_tid_last cyc %0d: got %b%b expected %b%b", i, m_axis_tid, m_if.tlast, exp_tid, exp_last);
                end
                n_cmp++;
                if (m_if.tdata !== beat_data(int'(exp_tid), exp_tid ? c1 : c0)) begin
                    n_bad++; $display("FAIL contention_data cyc %0d: got %h expected %h", i, m_if.tdata, beat_data(int'(exp_tid), exp_tid ? c1 : c0));
                end
            end
            if (s0_if.tready) c0++;
            if (s1_if.tready) c1++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int b = 0;
        logic exp_r;
        logic [DW-1:0] seen[$];
        do_reset();
        ctrl_enable = 1'b1;
        set_src(1, 1'b1, 0, 1'b0);
        tick();
        for (int c = 0; c < 12 && b < 3; c++) begin
            exp_r       = (c % 2 == 0);
            m_if.tready = exp_r;
            set_src(1, 1'b1, b, (b == 2));
            #1;
            n_cmp++;
            if ({m_if.tvalid, s1_if.tready, s0_if.tready} !== {1'b1, exp_r, 1'b0}) begin
                n_bad++; $display("FAIL bp_ready cyc %0d: got %b expected %b", c, {m_if.tvalid, s1_if.tready, s0_if.tready}, {1'b1, exp_r, 1'b0});
            end
            if (m_if.tvalid && m_if.tready) begin
                seen.push_back(m_if.tdata);
                b++;
            end
            tick();
        end
        n_cmp++;
        if (seen.size() != 3) begin n_bad++; $display("FAIL bp_beat_count: got %0d expected 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_cmp++;
            if (seen[k] !== beat_data(1, k)) begin n_bad++; $display("FAIL bp_beat %0d: got %h expected %h", k, seen[k], beat_data(1, k)); end
        end
        m_if.tready = 1'b1;
        set_src(1, 1'b0, 0, 1'b0);
        #1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_end_idle: got %b expected 0", m_if.tvalid); end
    endtask

    task automatic test_const_hold();
        do_reset();
        ctrl_enable    = 1'b1;
        ctrl_constant0 = 32'd1;
        ctrl_constant1 = 32'd7;
        set_src(1, 1'b1, 0, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b == 1) ctrl_constant1 = 32'd9;
            set_src(1, 1'b1, b, (b == 2));
            #1;
            n_cmp++;
            if (m_ctrl_constant !== 32'd7) begin n_bad++; $display("FAIL hold_const beat %0d: got %0d expected 7", b, m_ctrl_constant); end
            tick();
        end
        set_src(1, 1'b1, 0, 1'b1);
        #1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL hold_gap_tvalid: got %b expected 0", m_if.tvalid); end
        tick();
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_if.tlast, m_axis_tid} !== 3'b111 || m_ctrl_constant !== 32'd9) begin
            n_bad++; $display("FAIL hold_regrant: got %b const %0d expected 111 const 9", {m_if.tvalid, m_if.tlast, m_axis_tid}, m_ctrl_constant);
        end
        tick();
        set_src(1, 1'b0, 0, 1'b0);
        #1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL hold_single_beat_idle: got %b expected 0", m_if.tvalid); end
    endtask

    task automatic test_enable();
        do_reset();
        ctrl_enable    = 1'b1;
        ctrl_constant0 = 32'd3;
        set_src(0, 1'b1, 0, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b == 0) ctrl_enable = 1'b0;
            set_src(0, 1'b1, b, (b == 2));
            #1;
            n_cmp++;
            if ({m_if.tvalid, m_axis_tid} !== 2'b10) begin n_bad++; $display("FAIL enable_completes beat %0d: got %b expected 10", b, {m_if.tvalid, m_axis_tid}); end
            tick();
        end
        set_src(0, 1'b1, 0, 1'b0);
        set_src(1, 1'b1, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if ({m_if.tvalid, s0_if.tready, s1_if.tready} !== 3'b000) begin
                n_bad++; $display("FAIL enable_blocked cyc %0d: got %b expected 000", k, {m_if.tvalid, s0_if.tready, s1_if.tready});
            end
            tick();
        end
        ctrl_enable = 1'b1;
        tick();
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_axis_tid} !== 2'b11) begin n_bad++; $display("FAIL enable_resume_rr: got %b expected 11", {m_if.tvalid, m_axis_tid}); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] obs;
        do_reset();
        ctrl_enable    = 1'b1;
        ctrl_constant0 = 32'd4;
        ctrl_constant1 = 32'd6;
        set_src(0, 1'b1, 0, 1'b1);
        tick();
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_if.tlast, m_axis_tid} !== 3'b110) begin n_bad++; $display("FAIL rstmid_first: got %b expected 110", {m_if.tvalid, m_if.tlast, m_axis_tid}); end
        tick();
        set_src(0, 1'b0, 0, 1'b0);
        set_src(1, 1'b1, 0, 1'b0);
        tick();
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_axis_tid} !== 2'b11 || m_ctrl_constant !== 32'd6) begin
            n_bad++; $display("FAIL rstmid_s1_grant: got %b const %0d expected 11 const 6", {m_if.tvalid, m_axis_tid}, m_ctrl_constant);
        end
        tick();
        set_src(1, 1'b1, 1, 1'b0);
        s_axis_areset = 1'b1;
        #1;
        obs = {m_if.tvalid, s0_if.tready, s1_if.tready, m_axis_tid, (m_ctrl_constant != 32'd0)};
        n_cmp++;
        if (obs !== 5'b00000) begin n_bad++; $display("FAIL rstmid_outputs: got %b expected 00000", obs); end
        s_axis_areset = 1'b0;
        set_src(0, 1'b1, 0, 1'b0);
        tick();
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_axis_tid} !== 2'b10 || m_ctrl_constant !== 32'd4) begin
            n_bad++; $display("FAIL rstmid_s0_first: got %b const %0d expected 10 const 4", {m_if.tvalid, m_axis_tid}, m_ctrl_constant);
        end
    endtask

    task automatic send_pkt(input int src, input int n);
        int b = 0;
        int cyc = 0;
        while (b < n && cyc < 60) begin
            set_src(src, 1'b1, b, (b == n - 1));
            #1;
            if ((src == 0) ? s0_if.tready : s1_if.tready) begin
                n_cmp++;
                if (m_axis_tid !== TW'(src)) begin n_bad++; $display("FAIL send_tid src %0d: got %0d expected %0d", src, m_axis_tid, src); end
                b++;
            end
            tick();
            cyc++;
        end
        set_src(src, 1'b0, 0, 1'b0);
        n_cmp++;
        if (b != n) begin n_bad++; $display("FAIL send_timeout src %0d: got %0d beats expected %0d", src, b, n); end
    endtask

    task automatic test_stats();
        logic [31:0] exp0;
        logic [31:0] exp1;
`ifdef PC_CORE_ARB_STATS_EN
        exp0 = 32'd10;
        exp1 = 32'd3;
`else
        exp0 = 32'd0;
        exp1 = 32'd0;
`endif
        do_reset();
        ctrl_enable = 1'b1;
        send_pkt(0, 10);
        send_pkt(1, 3);
        #1;
        n_cmp++;
        if (stat_beats0 !== exp0) begin n_bad++; $display("FAIL stats0: got %0d expected %0d", stat_beats0, exp0); end
        n_cmp++;
        if (stat_beats1 !== exp1) begin n_bad++; $display("FAIL stats1: got %0d expected %0d", stat_beats1, exp1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_const_hold();
        test_enable();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
